// File: rtl/rob_pkg.sv
// Shared types and default constants for the reorder buffer.
// The entry record is sized by the package widths; AREG_W/DATA_W on the
// top level must not exceed ROB_AREG_W/ROB_DATA_W.
package rob_pkg;

  localparam int ROB_DEPTH          = 16;
  localparam int ROB_DISPATCH_WIDTH = 2;
  localparam int ROB_RETIRE_WIDTH   = 2;
  localparam int ROB_NUM_WB         = 2;
  localparam int ROB_AREG_W         = 5;
  localparam int ROB_DATA_W         = 32;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  exc;
    logic                  wen;
    logic [ROB_AREG_W-1:0] areg;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Head-run selector: given entry status rotated so lane 0 is the head,
// returns how many consecutive entries can retire and whether the head
// holds a completed exception.
module rob_retire_select
  import rob_pkg::*;
#(
  parameter  int RETIRE_WIDTH = ROB_RETIRE_WIDTH,
  localparam int CNT_W        = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic [RETIRE_WIDTH-1:0] valid_i,
  input  logic [RETIRE_WIDTH-1:0] done_i,
  input  logic [RETIRE_WIDTH-1:0] exc_i,
  output logic [CNT_W-1:0]        ret_cnt_o,
  output logic                    exc_at_head_o
);

  logic run_open;

  // Count the run of done, non-excepting entries; the first gap ends it.
  always_comb begin
    ret_cnt_o = '0;
    run_open  = 1'b1;
    for (int r = 0; r < RETIRE_WIDTH; r++) begin
      if (run_open && valid_i[r] && done_i[r] && !exc_i[r]) begin
        ret_cnt_o = ret_cnt_o + CNT_W'(1);
      end else begin
        run_open = 1'b0;
      end
    end
  end

  assign exc_at_head_o = valid_i[0] & done_i[0] & exc_i[0];

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: multi-lane in-order allocation, out-of-order writeback,
// in-order retirement of up to RETIRE_WIDTH entries per cycle, and a
// one-cycle flush when a completed exception reaches the head.
// Optional feature macro: ROB_WB_BYPASS_EN -- lets a writeback arriving this
// cycle complete a head-run entry and retire it in the same cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter  int DEPTH          = ROB_DEPTH,
  parameter  int DISPATCH_WIDTH = ROB_DISPATCH_WIDTH,
  parameter  int RETIRE_WIDTH   = ROB_RETIRE_WIDTH,
  parameter  int NUM_WB         = ROB_NUM_WB,
  parameter  int AREG_W         = ROB_AREG_W,
  parameter  int DATA_W         = ROB_DATA_W,
  localparam int TAG_W          = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DISPATCH_WIDTH-1:0]        disp_valid,
  input  logic [DISPATCH_WIDTH*AREG_W-1:0] disp_areg,
  input  logic [DISPATCH_WIDTH-1:0]        disp_wen,
  output logic                             disp_ready,
  output logic [DISPATCH_WIDTH*TAG_W-1:0]  disp_tag,
  input  logic [NUM_WB-1:0]                wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]          wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]         wb_data,
  input  logic [NUM_WB-1:0]                wb_exc,
  output logic [RETIRE_WIDTH-1:0]          ret_valid,
  output logic [RETIRE_WIDTH*AREG_W-1:0]   ret_areg,
  output logic [RETIRE_WIDTH*DATA_W-1:0]   ret_data,
  output logic [RETIRE_WIDTH-1:0]          ret_wen,
  output logic                             flush,
  output logic [TAG_W:0]                   count,
  output logic                             empty,
  output logic                             full
);

  localparam int CNT_W  = $clog2(RETIRE_WIDTH + 1);
  localparam int DCNT_W = $clog2(DISPATCH_WIDTH + 1);

  rob_entry_t         entry_q [DEPTH];
  rob_entry_t         entry_d [DEPTH];

  // Pointers carry a wrap bit above the index.
  logic [TAG_W:0]     head_q, head_d;
  logic [TAG_W:0]     tail_q, tail_d;
  logic [TAG_W:0]     count_q, count_d;
  logic               flush_q, flush_d;

  logic [TAG_W-1:0]   head_idx, tail_idx;
  logic [TAG_W-1:0]   alloc_idx [DISPATCH_WIDTH];
  logic [TAG_W-1:0]   ret_idx   [RETIRE_WIDTH];
  logic [TAG_W-1:0]   wb_tag_a  [NUM_WB];
  logic [DATA_W-1:0]  wb_data_a [NUM_WB];
  logic [NUM_WB-1:0]  wb_en;

  logic               space_ok;
  logic               accept;
  logic [DISPATCH_WIDTH-1:0] disp_fire;
  logic [DCNT_W-1:0]  n_disp;

  logic [RETIRE_WIDTH-1:0] sel_valid, sel_done, sel_exc;
  logic [DATA_W-1:0]  sel_data [RETIRE_WIDTH];
  logic [CNT_W-1:0]   n_ret_raw, n_ret;
  logic               exc_at_head;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];

  // Writebacks are dropped during the flush cycle.
  assign wb_en = wb_valid & {NUM_WB{~flush_q}};

  genvar gi;
  for (gi = 0; gi < NUM_WB; gi++) begin : g_wb
    assign wb_tag_a[gi]  = wb_tag[gi*TAG_W +: TAG_W];
    assign wb_data_a[gi] = wb_data[gi*DATA_W +: DATA_W];
  end

  // Dispatch credit comes from registered count only; no same-cycle retire credit.
  assign space_ok = ({1'b0, count_q} + (TAG_W+2)'(DISPATCH_WIDTH)) <= (TAG_W+2)'(DEPTH);
  assign accept   = space_ok && !flush_q && !rst;
  assign disp_ready = rst || (space_ok && !flush_q);

  for (gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_disp
    assign alloc_idx[gi]                  = tail_idx + TAG_W'(gi);
    assign disp_tag[gi*TAG_W +: TAG_W]    = alloc_idx[gi];
    assign disp_fire[gi]                  = accept & disp_valid[gi];
  end

  // Number of lanes allocated this cycle (lanes are contiguous from 0).
  always_comb begin
    n_disp = '0;
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (disp_fire[l]) n_disp = n_disp + DCNT_W'(1);
    end
  end

  for (gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_ret_idx
    assign ret_idx[gi] = head_idx + TAG_W'(gi);
  end

  // Gather head-run status; with the bypass, same-cycle writebacks complete entries.
  always_comb begin
    for (int r = 0; r < RETIRE_WIDTH; r++) begin
      sel_valid[r] = entry_q[ret_idx[r]].valid;
      sel_done[r]  = entry_q[ret_idx[r]].done;
      sel_exc[r]   = entry_q[ret_idx[r]].exc;
      sel_data[r]  = DATA_W'(entry_q[ret_idx[r]].data);
`ifdef ROB_WB_BYPASS_EN
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_en[p] && entry_q[ret_idx[r]].valid && (wb_tag_a[p] == ret_idx[r])) begin
          sel_done[r] = 1'b1;
          sel_exc[r]  = wb_exc[p];
          sel_data[r] = wb_data_a[p];
        end
      end
`endif
    end
  end

  rob_retire_select #(
    .RETIRE_WIDTH (RETIRE_WIDTH)
  ) u_retire_select (
    .valid_i       (sel_valid),
    .done_i        (sel_done),
    .exc_i         (sel_exc),
    .ret_cnt_o     (n_ret_raw),
    .exc_at_head_o (exc_at_head)
  );

  assign n_ret = (rst || flush_q) ? '0 : n_ret_raw;

  for (gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_ret
    assign ret_valid[gi]                  = CNT_W'(gi) < n_ret;
    assign ret_areg[gi*AREG_W +: AREG_W]  = AREG_W'(entry_q[ret_idx[gi]].areg);
    assign ret_wen[gi]                    = entry_q[ret_idx[gi]].wen;
    assign ret_data[gi*DATA_W +: DATA_W]  = sel_data[gi];
  end

  // Entry next state: writeback, then retire-clear, then allocation.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) entry_d[e] = entry_q[e];
    // Later ports overwrite earlier ones, so the highest port wins on duplicates.
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_en[p] && entry_q[wb_tag_a[p]].valid) begin
        entry_d[wb_tag_a[p]].done = 1'b1;
        entry_d[wb_tag_a[p]].exc  = wb_exc[p];
        entry_d[wb_tag_a[p]].data = ROB_DATA_W'(wb_data_a[p]);
      end
    end
    for (int r = 0; r < RETIRE_WIDTH; r++) begin
      if (CNT_W'(r) < n_ret) entry_d[ret_idx[r]].valid = 1'b0;
    end
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      if (disp_fire[l]) begin
        entry_d[alloc_idx[l]].valid = 1'b1;
        entry_d[alloc_idx[l]].done  = 1'b0;
        entry_d[alloc_idx[l]].exc   = 1'b0;
        entry_d[alloc_idx[l]].wen   = disp_wen[l];
        entry_d[alloc_idx[l]].areg  = ROB_AREG_W'(disp_areg[l*AREG_W +: AREG_W]);
        entry_d[alloc_idx[l]].data  = '0;
      end
    end
  end

  // Entry storage; reset and flush only need to drop the valid bits.
  always_ff @(posedge clk) begin
    if (rst || flush_q) begin
      for (int e = 0; e < DEPTH; e++) entry_q[e].valid <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) entry_q[e] <= entry_d[e];
    end
  end

  // Pointer, occupancy and flush next state.
  always_comb begin
    head_d  = head_q + (TAG_W+1)'(n_ret);
    tail_d  = tail_q + (TAG_W+1)'(n_disp);
    count_d = count_q + (TAG_W+1)'(n_disp) - (TAG_W+1)'(n_ret);
    flush_d = exc_at_head;
  end

  // Control registers; a flush cycle empties the buffer at its closing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
    end else if (flush_q) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  assign flush = flush_q && !rst;
  assign count = count_q;
  assign empty = rst || (head_q == tail_q);
  assign full  = !rst && (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (DEPTH=16, 2/2/2 lanes).
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int DW     = 2;
  localparam int RW     = 2;
  localparam int NWB    = 2;
  localparam int AREG_W = 5;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
`ifdef ROB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DW-1:0]          disp_valid;
  logic [DW*AREG_W-1:0]   disp_areg;
  logic [DW-1:0]          disp_wen;
  logic                   disp_ready;
  logic [DW*TAG_W-1:0]    disp_tag;
  logic [NWB-1:0]         wb_valid;
  logic [NWB*TAG_W-1:0]   wb_tag;
  logic [NWB*DATA_W-1:0]  wb_data;
  logic [NWB-1:0]         wb_exc;
  logic [RW-1:0]          ret_valid;
  logic [RW*AREG_W-1:0]   ret_areg;
  logic [RW*DATA_W-1:0]   ret_data;
  logic [RW-1:0]          ret_wen;
  logic                   flush;
  logic [TAG_W:0]         count;
  logic                   empty;
  logic                   full;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(
    .DEPTH(DEPTH), .DISPATCH_WIDTH(DW), .RETIRE_WIDTH(RW), .NUM_WB(NWB),
    .AREG_W(AREG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_areg(disp_areg), .disp_wen(disp_wen),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc),
    .ret_valid(ret_valid), .ret_areg(ret_areg), .ret_data(ret_data), .ret_wen(ret_wen),
    .flush(flush), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [AREG_W-1:0] areg_of(input int t);
    return AREG_W'(((t % 16) * 3) + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    disp_valid = '0; disp_areg = '0; disp_wen = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_exc = '0;
  endtask

  task automatic clear_wb();
    wb_valid = '0; wb_tag = '0; wb_data = '0; wb_exc = '0;
  endtask

  task automatic set_wb(input int p, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d, input logic e);
    wb_valid[p] = 1'b1;
    wb_tag[p*TAG_W +: TAG_W] = t;
    wb_data[p*DATA_W +: DATA_W] = d;
    wb_exc[p] = e;
    $display("wb port %0d tag %0d data %08h exc %0d", p, t, d, e);
  endtask

  task automatic dispatch2(input int t);
    disp_valid = 2'b11;
    disp_areg  = {areg_of(t + 1), areg_of(t)};
    disp_wen   = 2'b11;
    $display("dispatch 2 lanes, expecting tags %0d,%0d", t % 16, (t + 1) % 16);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    disp_valid = 2'b11; disp_areg = '1; disp_wen = 2'b11;
    tick(); tick(); #2;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", disp_ready); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b expected 0", flush); end
    checks++; if (ret_valid !== 2'b00) begin errors++; $display("FAIL reset_ret_valid: got %b expected 00", ret_valid); end
    rst = 1'b0;
    clear_inputs();
    #2;
    checks++; if (disp_tag[3:0] !== 4'd0) begin errors++; $display("FAIL reset_tail_tag: got %0d expected 0", disp_tag[3:0]); end
    $display("reset released");
  endtask

  task automatic test_fill();
    for (int c = 0; c < 8; c++) begin
      dispatch2(2 * c);
      #2;
      checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL fill_ready c%0d: got %0b expected 1", c, disp_ready); end
      checks++; if (disp_tag !== {4'(2*c+1), 4'(2*c)}) begin errors++; $display("FAIL fill_tags c%0d: got %h expected %h", c, disp_tag, {4'(2*c+1), 4'(2*c)}); end
      tick();
    end
    clear_inputs();
    #2;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", full); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_low: got %0b expected 0", disp_ready); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", count); end
    checks++; if (ret_valid !== 2'b00) begin errors++; $display("FAIL fill_no_retire: got %b expected 00", ret_valid); end
  endtask

  task automatic test_wb_order();
    set_wb(0, 4'd1, 32'hD000_0001, 1'b0);
    #2;
    checks++; if (ret_valid !== 2'b00) begin errors++; $display("FAIL order_wb1_retire: got %b expected 00", ret_valid); end
    tick(); clear_wb();
    set_wb(0, 4'd0, 32'hD000_0000, 1'b0);
    #2;
    checks++; if (ret_valid !== (BYP ? 2'b11 : 2'b00)) begin errors++; $display("FAIL order_wb0_cycle: got %b expected %b", ret_valid, (BYP ? 2'b11 : 2'b00)); end
    if (!BYP) begin tick(); clear_wb(); #2; end
    checks++; if (ret_valid !== 2'b11) begin errors++; $display("FAIL order_retire_valid: got %b expected 11", ret_valid); end
    checks++; if (ret_areg !== {areg_of(1), areg_of(0)}) begin errors++; $display("FAIL order_areg: got %h expected %h", ret_areg, {areg_of(1), areg_of(0)}); end
    checks++; if (ret_data !== {32'hD000_0001, 32'hD000_0000}) begin errors++; $display("FAIL order_data: got %h expected d0000001d0000000", ret_data); end
    $display("retire tags 0,1");
    tick(); clear_wb(); #2;
    checks++; if (count !== 5'd14) begin errors++; $display("FAIL order_count: got %0d expected 14", count); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL order_ready: got %0b expected 1", disp_ready); end
  endtask

  task automatic test_exception();
    int lat;
    set_wb(0, 4'd3, 32'hD000_0003, 1'b0);
    set_wb(1, 4'd2, 32'hD000_0002, 1'b1);
    #2;
    checks++; if (ret_valid !== 2'b00) begin errors++; $display("FAIL exc_no_retire: got %b expected 00", ret_valid); end
    tick(); clear_wb();
    lat = 1;
    while (flush !== 1'b1 && lat < 6) begin tick(); lat++; end
    checks++; if (lat !== (BYP ? 1 : 2)) begin errors++; $display("FAIL exc_flush_latency: got %0d expected %0d", lat, (BYP ? 1 : 2)); end
    checks++; if (ret_valid !== 2'b00) begin errors++; $display("FAIL exc_flush_ret: got %b expected 00", ret_valid); end
    dispatch2(4);
    set_wb(0, 4'd4, 32'hBAD0_0004, 1'b0);
    #2;
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL exc_flush_ready: got %0b expected 0", disp_ready); end
    tick(); clear_inputs(); #2;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL exc_flush_width: got %0b expected 0", flush); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL exc_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL exc_empty: got %0b expected 1", empty); end
    checks++; if (disp_tag !== 8'h10) begin errors++; $display("FAIL exc_next_tags: got %h expected 10", disp_tag); end
    dispatch2(0);
    tick(); clear_inputs(); #2;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL exc_redispatch_count: got %0d expected 2", count); end
  endtask

  task automatic test_wrap();
    for (int c = 1; c < 7; c++) begin dispatch2(2 * c); tick(); end
    disp_valid = 2'b01; disp_areg = {5'd0, areg_of(14)}; disp_wen = 2'b01;
    tick(); clear_inputs(); #2;
    checks++; if (count !== 5'd15) begin errors++; $display("FAIL wrap_count15: got %0d expected 15", count); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL wrap_ready15: got %0b expected 0", disp_ready); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full15: got %0b expected 0", full); end
    for (int k = 0; k < 6; k++) begin
      set_wb(0, 4'(2*k), 32'hD000_0000 + 32'(2*k), 1'b0);
      set_wb(1, 4'(2*k+1), 32'hD000_0000 + 32'(2*k+1), 1'b0);
      tick(); clear_wb();
    end
    set_wb(0, 4'd12, 32'hD000_000C, 1'b0);
    tick(); clear_wb();
    tick(); tick(); tick(); #2;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL wrap_drain_count: got %0d expected 2", count); end
    checks++; if (ret_valid !== 2'b00) begin errors++; $display("FAIL wrap_drain_idle: got %b expected 00", ret_valid); end
    set_wb(0, 4'd13, 32'hD000_000D, 1'b0);
    set_wb(1, 4'd14, 32'hD000_000E, 1'b0);
    if (!BYP) begin tick(); clear_wb(); end
    dispatch2(15);
    #2;
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %0b expected 1", disp_ready); end
    checks++; if (disp_tag !== 8'h0F) begin errors++; $display("FAIL wrap_tags: got %h expected 0f", disp_tag); end
    checks++; if (ret_valid !== 2'b11) begin errors++; $display("FAIL wrap_concurrent_ret: got %b expected 11", ret_valid); end
    checks++; if (ret_areg !== {areg_of(14), areg_of(13)}) begin errors++; $display("FAIL wrap_ret_areg: got %h expected %h", ret_areg, {areg_of(14), areg_of(13)}); end
    tick(); clear_inputs(); #2;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL wrap_count_concurrent: got %0d expected 2", count); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL wrap_status: got empty %0b full %0b expected 0 0", empty, full); end
    set_wb(0, 4'd15, 32'hD000_000F, 1'b0);
    set_wb(1, 4'd0, 32'hD000_0100, 1'b0);
    if (!BYP) begin tick(); clear_wb(); end
    #2;
    checks++; if (ret_valid !== 2'b11) begin errors++; $display("FAIL wrap_ret2_valid: got %b expected 11", ret_valid); end
    checks++; if (ret_areg !== {areg_of(0), areg_of(15)}) begin errors++; $display("FAIL wrap_ret2_areg: got %h expected %h", ret_areg, {areg_of(0), areg_of(15)}); end
    checks++; if (ret_data !== {32'hD000_0100, 32'hD000_000F}) begin errors++; $display("FAIL wrap_ret2_data: got %h expected d0000100d000000f", ret_data); end
    tick(); clear_inputs(); #2;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_final_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL wrap_final_status: got empty %0b full %0b expected 1 0", empty, full); end
  endtask

  task automatic test_latency();
    logic [DATA_W-1:0] got_data;
    logic [AREG_W-1:0] got_areg;
    logic              got_wen;
    got_data = '0; got_areg = '0; got_wen = 1'b1;
    disp_valid = 2'b01; disp_areg = {5'd0, 5'd7}; disp_wen = 2'b00;
    #2;
    checks++; if (disp_tag[3:0] !== 4'd1) begin errors++; $display("FAIL lat_tag: got %0d expected 1", disp_tag[3:0]); end
    tick(); clear_inputs();
    set_wb(0, 4'd1, 32'h0000_0011, 1'b0);
    set_wb(1, 4'd1, 32'h0000_0055, 1'b0);
    #2;
    checks++; if (ret_valid !== (BYP ? 2'b01 : 2'b00)) begin errors++; $display("FAIL lat_cycle_n: got %b expected %b", ret_valid, (BYP ? 2'b01 : 2'b00)); end
    if (ret_valid[0]) begin got_data = ret_data[31:0]; got_areg = ret_areg[4:0]; got_wen = ret_wen[0]; end
    tick(); clear_wb(); #2;
    checks++; if (ret_valid !== (BYP ? 2'b00 : 2'b01)) begin errors++; $display("FAIL lat_cycle_n1: got %b expected %b", ret_valid, (BYP ? 2'b00 : 2'b01)); end
    if (ret_valid[0]) begin got_data = ret_data[31:0]; got_areg = ret_areg[4:0]; got_wen = ret_wen[0]; end
    checks++; if (got_data !== 32'h0000_0055) begin errors++; $display("FAIL lat_dup_port_data: got %08h expected 00000055", got_data); end
    checks++; if (got_areg !== 5'd7 || got_wen !== 1'b0) begin errors++; $display("FAIL lat_areg_wen: got %0d/%0b expected 7/0", got_areg, got_wen); end
    $display("single retire tag 1");
    tick(); #2;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_empty: got %0b expected 1", empty); end
  endtask

  task automatic test_rst_midflight();
    for (int c = 0; c < 5; c++) begin dispatch2(2 + 2 * c); tick(); end
    clear_inputs(); #2;
    checks++; if (count !== 5'd10) begin errors++; $display("FAIL rst_pre_count: got %0d expected 10", count); end
    rst = 1'b1;
    set_wb(0, 4'd2, 32'h0000_0002, 1'b1);
    set_wb(1, 4'd3, 32'h0000_0003, 1'b0);
    #2;
    checks++; if (ret_valid !== 2'b00 || flush !== 1'b0) begin errors++; $display("FAIL rst_during: got ret %b flush %0b expected 00 0", ret_valid, flush); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL rst_during_ready: got %0b expected 1", disp_ready); end
    tick(); rst = 1'b0; clear_inputs(); #2;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b expected 1", empty); end
    checks++; if (ret_valid !== 2'b00 || flush !== 1'b0) begin errors++; $display("FAIL rst_after: got ret %b flush %0b expected 00 0", ret_valid, flush); end
    tick(); #2;
    checks++; if (flush !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL rst_settled: got flush %0b count %0d expected 0 0", flush, count); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_fill();
    test_wb_order();
    test_exception();
    test_wrap();
    test_latency();
    test_rst_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
